// File: rtl/mult_div_unit.sv
// Multicycle signed multiply / restoring divide sequencer with HI/LO result registers.
// Iterates on operand magnitudes for WIDTH cycles, then applies the sign in a single fix-up step.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, MULT, DIV, FIX, DONE} state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic               is_div, res_sign, a_sign, b_zero;
  logic [WIDTH-1:0]   opnd;     // multiplicand (mult) or divisor (div) magnitude
  logic [2*WIDTH-1:0] acc;      // {upper product / remainder, multiplier / quotient}

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               last_iter;
  logic               accept;

  // Magnitudes stay unsigned, so |-2^(WIDTH-1)| = 2^(WIDTH-1) is represented exactly.
  assign mag_a     = operand_a[WIDTH-1] ? -operand_a : operand_a;
  assign mag_b     = operand_b[WIDTH-1] ? -operand_b : operand_b;
  assign last_iter = (cnt == CW'(WIDTH - 1));
  assign accept    = (state == IDLE) && (start_mult || start_div);

  // Multiply step: conditional add into the upper half (with carry), then shift right.
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     mult_sum;
  logic [2*WIDTH-1:0] mult_step;

  assign addend    = acc[0] ? opnd : '0;
  assign mult_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
  assign mult_step = {mult_sum, acc[WIDTH-1:1]};

  // Restoring divide step: shift {rem,quot} left, subtract the divisor when it fits.
  logic [WIDTH:0]     rem_sh, rem_sub;
  logic               rem_ge;
  logic [2*WIDTH-1:0] div_step;

  assign rem_sh   = acc[2*WIDTH-1:WIDTH-1];
  assign rem_ge   = (rem_sh >= {1'b0, opnd});
  assign rem_sub  = rem_ge ? (rem_sh - {1'b0, opnd}) : rem_sh;
  assign div_step = {rem_sub[WIDTH-1:0], acc[WIDTH-2:0], rem_ge};

  // Sign fix-up of the magnitude result; the quotient therefore truncates toward zero.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

  assign prod_fix = res_sign ? -acc : acc;
  assign quot_fix = res_sign ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_fix  = a_sign ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  assign fix_hi   = is_div ? rem_fix  : prod_fix[2*WIDTH-1:WIDTH];
  assign fix_lo   = is_div ? quot_fix : prod_fix[WIDTH-1:0];

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: state_nxt gets a default first, so no path through the case can infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start_mult)     state_nxt = MULT;
            else if (start_div) state_nxt = DIV;
      MULT: if (last_iter)      state_nxt = FIX;
      DIV:  if (b_zero)         state_nxt = DONE;
            else if (last_iter) state_nxt = FIX;
      FIX:                      state_nxt = DONE;
      DONE:                     state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state != IDLE);
    done        = (state == DONE);
    div_by_zero = (state == DONE) && is_div && b_zero;
  end

  // NOTE: every datapath register, including hi/lo, is cleared by reset so nothing powers up as X.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt      <= '0;
      is_div   <= 1'b0;
      res_sign <= 1'b0;
      a_sign   <= 1'b0;
      b_zero   <= 1'b0;
      opnd     <= '0;
      acc      <= '0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      unique case (state)
        IDLE: if (accept) begin
          is_div   <= !start_mult;
          res_sign <= operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
          a_sign   <= operand_a[WIDTH-1];
          b_zero   <= !start_mult && (operand_b == '0);
          opnd     <= start_mult ? mag_a : mag_b;
          acc      <= {{WIDTH{1'b0}}, (start_mult ? mag_b : mag_a)};
          cnt      <= '0;
        end
        MULT: begin
          acc <= mult_step;
          cnt <= last_iter ? '0 : cnt + CW'(1);
        end
        DIV: if (!b_zero) begin
          acc <= div_step;
          cnt <= last_iter ? '0 : cnt + CW'(1);
        end
        FIX: begin
          hi <= fix_hi;
          lo <= fix_lo;
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit: hand-computed results, latency, start handling, reset abort.
module tb_mult_div_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        start_mult, start_div;
  logic [31:0] operand_a, operand_b;
  logic [31:0] hi, lo;
  logic        busy, done, div_by_zero;

  int n_vec = 0;
  int n_err = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clock      (clock),
    .reset      (reset),
    .start_mult (start_mult),
    .start_div  (start_div),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .hi         (hi),
    .lo         (lo),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Cycle n is the interval after the n-th rising edge following the start edge (start edge = cycle 1).
  task automatic run_op(input string tag, input logic m, input logic d,
                        input logic [31:0] a, input logic [31:0] b, input int exp_lat,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo, input logic exp_dz);
    int lat;
    @(negedge clock);
    operand_a = a; operand_b = b; start_mult = m; start_div = d;
    @(posedge clock); #1;
    start_mult = 1'b0; start_div = 1'b0;
    lat = 1;
    check({tag, "_busy"}, 64'(busy), 64'd1);
    while (!done && lat < 100) begin
      @(posedge clock); #1;
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_dz"}, 64'(div_by_zero), 64'(exp_dz));
    check({tag, "_hi"}, 64'(hi), 64'(exp_hi));
    check({tag, "_lo"}, 64'(lo), 64'(exp_lo));
    @(posedge clock); #1;
    check({tag, "_done_drop"}, 64'(done), 64'd0);
    check({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, first, pulses;
    logic [31:0] cap_hi, cap_lo;

    reset = 1'b0; start_mult = 1'b0; start_div = 1'b0;
    operand_a = '0; operand_b = '0;
    #2;
    check("rst_hi",   64'(hi), 64'd0);
    check("rst_lo",   64'(lo), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_dz",   64'(div_by_zero), 64'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;

    run_op("mul_7xm3",    1, 0, 32'h0000_0007, 32'hFFFF_FFFD, 34, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0);
    run_op("div_m7d2",    0, 1, 32'hFFFF_FFF9, 32'h0000_0002, 34, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
    run_op("div_100dm7",  0, 1, 32'h0000_0064, 32'hFFFF_FFF9, 34, 32'h0000_0002, 32'hFFFF_FFF2, 0);
    run_op("mul_m100sq",  1, 0, 32'hFFFF_FF9C, 32'hFFFF_FF9C, 34, 32'h0000_0000, 32'h0000_2710, 0);
    run_op("div_9d4",     0, 1, 32'h0000_0009, 32'h0000_0004, 34, 32'h0000_0001, 32'h0000_0002, 0);
    run_op("div_by_zero", 0, 1, 32'h0000_0064, 32'h0000_0000,  2, 32'h0000_0001, 32'h0000_0002, 1);
    run_op("div_min_m1",  0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'h0000_0000, 32'h8000_0000, 0);
    run_op("mul_min_sq",  1, 0, 32'h8000_0000, 32'h8000_0000, 34, 32'h4000_0000, 32'h0000_0000, 0);
    run_op("both_starts", 1, 1, 32'h0000_0006, 32'h0000_0007, 34, 32'h0000_0000, 32'h0000_002A, 0);

    // A start_div during a multiply must be ignored, leaving one done pulse and the product intact.
    @(negedge clock);
    operand_a = 32'h0001_E240; operand_b = 32'hFFFF_FCEB; start_mult = 1'b1;
    @(posedge clock); #1;
    start_mult = 1'b0;
    n = 1; first = 0; pulses = 0; cap_hi = '0; cap_lo = '0;
    repeat (45) begin
      if (done) begin
        pulses++;
        if (first == 0) begin
          first = n; cap_hi = hi; cap_lo = lo;
        end
      end
      start_div = (n == 10);
      @(posedge clock); #1;
      n++;
    end
    start_div = 1'b0;
    check("midstart_pulses", 64'(pulses), 64'd1);
    check("midstart_lat",    64'(first),  64'd34);
    check("midstart_hi",     64'(cap_hi), 64'hFFFF_FFFF);
    check("midstart_lo",     64'(cap_lo), 64'hFA31_B0C0);

    // Reset during a multiply aborts it at once and produces no done pulse.
    @(negedge clock);
    operand_a = 32'h0000_0007; operand_b = 32'hFFFF_FFFD; start_mult = 1'b1;
    @(posedge clock); #1;
    start_mult = 1'b0;
    repeat (14) @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    check("abort_hi",   64'(hi), 64'd0);
    check("abort_lo",   64'(lo), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(posedge clock); #1;
      if (done) pulses++;
    end
    check("abort_no_done", 64'(pulses), 64'd0);
    check("abort_idle",    64'(busy), 64'd0);

    run_op("post_rst_div", 0, 1, 32'h0000_0009, 32'h0000_0004, 34, 32'h0000_0001, 32'h0000_0002, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
